// File: rtl/axis2fifo.sv
// AXI-Stream packet to FIFO-write bridge: buffers one packet of up to PKT_LEN beats, then drains it.
// Optional length checking (len_err output, FLUSH state) is enabled by defining AXIS2FIFO_LEN_CHECK_EN.
module axis2fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    output logic                  pkt_done,
`ifdef AXIS2FIFO_LEN_CHECK_EN
    output logic                  len_err,
`endif
    output logic                  busy
);
    localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE, RECV, DRAIN
`ifdef AXIS2FIFO_LEN_CHECK_EN
        , FLUSH
`endif
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] buffer [PKT_LEN];
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [4:0]            count;
    logic                  accept, store, full_beat, last_wr;
`ifdef AXIS2FIFO_LEN_CHECK_EN
    logic                  long_pkt;
`endif

`ifdef AXIS2FIFO_LEN_CHECK_EN
    assign s_axis_tready = (state == RECV) || (state == FLUSH);
`else
    assign s_axis_tready = (state == RECV);
`endif
    assign busy         = (state != IDLE);
    assign accept       = s_axis_tvalid && s_axis_tready;
    assign store        = accept && (state == RECV);
    assign full_beat    = (count + 5'd1) == 5'(PKT_LEN);
    assign fifo_wr_en   = (state == DRAIN) && !fifo_full;
    assign fifo_wr_data = buffer[rd_idx];
    assign last_wr      = fifo_wr_en && (5'(rd_idx) == (count - 5'd1));

    // Buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (store)
            buffer[wr_idx] <= s_axis_tdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            pkt_done <= 1'b0;
`ifdef AXIS2FIFO_LEN_CHECK_EN
            len_err  <= 1'b0;
            long_pkt <= 1'b0;
`endif
        end else begin
            pkt_done <= 1'b0;
`ifdef AXIS2FIFO_LEN_CHECK_EN
            len_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                    count  <= '0;
`ifdef AXIS2FIFO_LEN_CHECK_EN
                    long_pkt <= 1'b0;
`endif
                    state  <= RECV;
                end
                RECV: begin
                    if (store) begin
                        wr_idx <= wr_idx + 1'b1;
                        count  <= count + 5'd1;
                        if (s_axis_tlast || full_beat)
                            state <= DRAIN;
`ifdef AXIS2FIFO_LEN_CHECK_EN
                        long_pkt <= full_beat && !s_axis_tlast;
`endif
                    end
                end
                DRAIN: begin
                    if (fifo_wr_en) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (last_wr) begin
`ifdef AXIS2FIFO_LEN_CHECK_EN
                            // Long packets report only after the tail is flushed.
                            if (long_pkt) begin
                                state <= FLUSH;
                            end else begin
                                pkt_done <= 1'b1;
                                len_err  <= (count < 5'(PKT_LEN));
                                state    <= IDLE;
                            end
`else
                            pkt_done <= 1'b1;
                            state    <= IDLE;
`endif
                        end
                    end
                end
`ifdef AXIS2FIFO_LEN_CHECK_EN
                FLUSH: begin
                    if (accept && s_axis_tlast) begin
                        pkt_done <= 1'b1;
                        len_err  <= 1'b1;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
